// File: rtl/unary_pkg.sv
// Shared definitions for the unary stream feeder: operand width, FSM states
// and the DRAIN watchdog limit.
package unary_pkg;

  localparam int W = 12;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned wd_limit(input int unsigned w);
    return (32'd1 << w) + 32'd2;
  endfunction

  // A healthy drain lasts at most 2^W+1 cycles, so reaching this means the adder is stuck.
  localparam int unsigned WD_LIMIT = wd_limit(W);

endpackage

// File: rtl/unary_stream_feeder_if.sv
// Operand/result handshakes plus the unary adder pins, bundled for the feeder.
interface unary_stream_feeder_if #(
  parameter int W = unary_pkg::W
);

  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         A;
  logic         B;
  logic         en;
  logic         read_or_write;
  logic         dout;
  logic         C;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic         res_err;

  modport master (
    output op_valid, op_a, op_b, res_ready, dout, C,
    input  op_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry, res_err
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready, dout, C,
    output op_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry, res_err
  );

endinterface

// File: rtl/unary_pulse_gen.sv
// Loadable down-counter that emits one registered pulse per remaining count.
module unary_pulse_gen #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic         active,
  input  logic [W-1:0] val,
  output logic         more,
  output logic         pulse
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_q, pulse_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // more looks one cycle ahead so the pulse can be registered.
  assign more    = (cnt_d != '0);
  assign pulse_d = active && more;
  assign pulse   = pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/unary_stream_feeder.sv
// Converts a binary operand pair to unary streams for the adder, drains the
// adder's unary result back to binary and checks it against a direct sum.
module unary_stream_feeder #(
  parameter int W = unary_pkg::W
) (
  input  logic                clk,
  input  logic                rst,
  unary_stream_feeder_if.slave bus
);
  import unary_pkg::*;

  localparam int DCNT_W = W + 2;
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_TWO = DCNT_W'(2);
  localparam logic [DCNT_W-1:0] DCNT_WD  = DCNT_W'(wd_limit(W));

  state_t              state_q, state_d;
  logic                op_ready_q, op_ready_d;
  logic                en_q, en_d;
  logic                rw_q, rw_d;
  logic                valid_q, valid_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  logic [W-1:0]        sum_q, sum_d;
  logic [W:0]          exp_q, exp_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                load, dec, active;
  logic                more_a, more_b, pulse_a, pulse_b;

  assign load   = (state_q == IDLE) && bus.op_valid;
  assign dec    = (state_q == STREAM);
  assign active = (state_d == STREAM);

  unary_pulse_gen #(.W(W)) u_gen_a (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .active(active),
    .val(bus.op_a), .more(more_a), .pulse(pulse_a)
  );

  unary_pulse_gen #(.W(W)) u_gen_b (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .active(active),
    .val(bus.op_b), .more(more_b), .pulse(pulse_b)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    exp_d   = exp_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          sum_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          dcnt_d  = '0;
          exp_d   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
          state_d = ((bus.op_a == '0) && (bus.op_b == '0)) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        carry_d = carry_q | bus.C;
        if (!more_a && !more_b) state_d = FLUSH;
      end
      FLUSH: begin
        carry_d = carry_q | bus.C;
        dcnt_d  = DCNT_ONE;
        state_d = DRAIN;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        // The first drain cycle still shows dout from the accumulate phase.
        if ((dcnt_q >= DCNT_TWO) && bus.dout) sum_d = sum_q + 1'b1;
        if (dcnt_q == DCNT_WD) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if ((dcnt_q >= DCNT_TWO) && !bus.dout) begin
          err_d   = (sum_d != exp_q[W-1:0]) || (carry_q != exp_q[W]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    op_ready_d = (state_d == IDLE);
    en_d       = (state_d == STREAM) || (state_d == FLUSH) || (state_d == DRAIN);
    rw_d       = (state_d == DRAIN);
    valid_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_ready_q <= 1'b1;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      valid_q    <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      exp_q      <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      exp_q      <= exp_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign bus.op_ready      = op_ready_q;
  assign bus.A             = pulse_a;
  assign bus.B             = pulse_b;
  assign bus.en            = en_q;
  assign bus.read_or_write = rw_q;
  assign bus.res_valid     = valid_q;
  assign bus.res_sum       = sum_q;
  assign bus.res_carry     = carry_q;
  assign bus.res_err       = err_q;

endmodule
